// File: rtl/glb_mc_tag_bus_if.sv
// Bus-side bundle of the multicast tag bus: source push port plus the shared
// PE delivery port (per-PE valid/ready, one shared payload).
interface glb_mc_tag_bus_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_ROW    = 4,
    parameter int NUM_COL    = 8,
    parameter int TAG_W      = $clog2(NUM_COL) + 1
);
    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_WIDTH-1:0]         in_data;
    logic [TAG_W-1:0]              in_row_tag;
    logic [TAG_W-1:0]              in_col_tag;
    logic [NUM_ROW*NUM_COL-1:0]    pe_valid;
    logic [NUM_ROW*NUM_COL-1:0]    pe_ready;
    logic [DATA_WIDTH-1:0]         pe_data;

    // Environment side: drives source words and PE readiness.
    modport master (
        output in_valid, in_data, in_row_tag, in_col_tag, pe_ready,
        input  in_ready, pe_valid, pe_data
    );

    // Bus side: accepts source words and presents them to the PEs.
    modport slave (
        input  in_valid, in_data, in_row_tag, in_col_tag, pe_ready,
        output in_ready, pe_valid, pe_data
    );
endinterface

// File: rtl/glb_mc_tag_bus.sv
// Global multicast tag bus: input FIFO feeding a single output stage whose
// pending mask selects every enabled PE whose row/col tags match the word.
// Tags come from automatic allocation (AUTO) or runtime cfg writes.
module glb_mc_tag_bus #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_ROW    = 4,
    parameter int NUM_COL    = 8,
    parameter int TAG_W      = $clog2(NUM_COL) + 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic                                 auto_req,
    input  logic [7:0]                           kernel_size,
    output logic                                 busy,
    input  logic                                 cfg_we,
    input  logic [$clog2(NUM_ROW*NUM_COL)-1:0]   cfg_idx,
    input  logic                                 cfg_en,
    input  logic [TAG_W-1:0]                     cfg_row_tag,
    input  logic [TAG_W-1:0]                     cfg_col_tag,
    glb_mc_tag_bus_if.slave                      bus,
    output logic                                 err_nomatch,
    output logic [15:0]                          drop_cnt
);
    localparam int NUM_PE = NUM_ROW * NUM_COL;
    localparam int IDX_W  = $clog2(NUM_PE);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int ENT_W  = DATA_WIDTH + 2 * TAG_W;
    localparam logic [TAG_W-1:0] BCAST    = '1;
    localparam logic [PTR_W:0]   FULL_CNT = FIFO_DEPTH[PTR_W:0];
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

    typedef enum logic [1:0] {S_AUTO, S_RUN, S_FLUSH} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   auto_idx_q, auto_idx_d;
    logic               flush_cnt_q, flush_cnt_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;

    logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;

    logic [NUM_PE-1:0]  en_q;
    logic [TAG_W-1:0]   row_tag_q [NUM_PE];
    logic [TAG_W-1:0]   col_tag_q [NUM_PE];

    logic [NUM_PE-1:0]     pending_q, pending_d;
    logic [DATA_WIDTH-1:0] pe_data_q, pe_data_d;
    logic                  err_q, err_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    logic                  run, flush_now, push, load, auto_go;
    logic [NUM_PE-1:0]     pend_after, match;
    logic [DATA_WIDTH-1:0] head_data;
    logic [TAG_W-1:0]      head_row, head_col;
    logic [IDX_W-1:0]      auto_row, auto_col;
    logic                  auto_en;
    logic                  tag_we;
    logic [IDX_W-1:0]      tag_widx;
    logic                  tag_wen;
    logic [TAG_W-1:0]      tag_wrow, tag_wcol;

    assign run        = (state_q == S_RUN);
    assign flush_now  = flush && (run || state_q == S_FLUSH);
    assign pend_after = pending_q & ~bus.pe_ready;
    // in_ready_q is only ever high in RUN, so it already gates the push.
    assign push       = bus.in_valid && in_ready_q && !flush_now;
    // Stage reloads on the same edge it frees, giving 1 word/cycle.
    assign load       = run && !flush && (pend_after == '0) && (count_q != '0);
    assign auto_go    = run && !flush && auto_req && (count_q == '0) && (pending_q == '0);

    assign {head_row, head_col, head_data} = fifo_mem[rd_ptr_q];

    // Match mask for the FIFO head against the tags as they stand now.
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_match
        assign match[gi] = en_q[gi]
                        && (head_row == row_tag_q[gi] || head_row == BCAST)
                        && (head_col == col_tag_q[gi] || head_col == BCAST);
    end

    // Automatic allocation: PE(r,c) enabled when both r and c are below kernel_size.
    assign auto_row = auto_idx_q / IDX_W'(NUM_COL);
    assign auto_col = auto_idx_q % IDX_W'(NUM_COL);
    assign auto_en  = (32'(auto_col) < 32'(kernel_size)) && (32'(auto_row) < 32'(kernel_size));

    // Select the tag write source: allocation walk in AUTO, cfg port in RUN.
    always_comb begin
        tag_we   = 1'b0;
        tag_widx = cfg_idx;
        tag_wen  = cfg_en;
        tag_wrow = cfg_row_tag;
        tag_wcol = cfg_col_tag;
        if (state_q == S_AUTO) begin
            tag_we   = 1'b1;
            tag_widx = auto_idx_q;
            tag_wen  = auto_en;
            tag_wrow = TAG_W'(auto_row);
            tag_wcol = TAG_W'(auto_col);
        end else if (run && !flush && cfg_we) begin
            tag_we   = 1'b1;
        end
    end

    // Next-state logic for AUTO walk, RUN and the two-cycle FLUSH.
    always_comb begin
        state_d     = state_q;
        auto_idx_d  = auto_idx_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            S_AUTO: begin
                auto_idx_d = auto_idx_q + IDX_W'(1);
                if (auto_idx_q == LAST_IDX) begin
                    state_d    = S_RUN;
                    auto_idx_d = '0;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = 1'b0;
                end else if (auto_go) begin
                    state_d    = S_AUTO;
                    auto_idx_d = '0;
                end
            end
            S_FLUSH: begin
                if (flush) begin
                    flush_cnt_d = 1'b0;
                end else if (flush_cnt_q) begin
                    state_d = S_RUN;
                end else begin
                    flush_cnt_d = 1'b1;
                end
            end
            default: state_d = S_AUTO;
        endcase
        busy_d = (state_d != S_RUN);
    end

    // FIFO pointer/occupancy update; flush empties it outright.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = load ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !load)
            count_d = count_q + (PTR_W+1)'(1);
        else if (!push && load)
            count_d = count_q - (PTR_W+1)'(1);
        if (flush_now) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        in_ready_d = (state_d == S_RUN) && (count_d != FULL_CNT);
    end

    // Output stage: retire accepting PEs, load the head, or drop an unmatched word.
    always_comb begin
        pending_d  = pend_after;
        pe_data_d  = pe_data_q;
        err_d      = 1'b0;
        drop_cnt_d = drop_cnt_q;
        if (flush_now) begin
            pending_d = '0;
        end else if (load) begin
            if (match != '0) begin
                pending_d = match;
                pe_data_d = head_data;
            end else begin
                pending_d = '0;
                err_d     = 1'b1;
                if (drop_cnt_q != 16'hFFFF)
                    drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    // FSM registers and its registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_AUTO;
            auto_idx_q  <= '0;
            flush_cnt_q <= 1'b0;
            busy_q      <= 1'b1;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            auto_idx_q  <= auto_idx_d;
            flush_cnt_q <= flush_cnt_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are only meaningful below count_q.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_q] <= {bus.in_row_tag, bus.in_col_tag, bus.in_data};
    end

    // Per-PE tag registers.
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_tag
        logic sel;
        assign sel = tag_we && (tag_widx == IDX_W'(gi));
        // Update this PE's enable and tags when it is the write target.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                en_q[gi]      <= 1'b0;
                row_tag_q[gi] <= '0;
                col_tag_q[gi] <= '0;
            end else if (sel) begin
                en_q[gi]      <= tag_wen;
                row_tag_q[gi] <= tag_wrow;
                col_tag_q[gi] <= tag_wcol;
            end
        end
    end

    // Output stage and drop reporting registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            pe_data_q  <= '0;
            err_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            pe_data_q  <= pe_data_d;
            err_q      <= err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign busy         = busy_q;
    assign bus.in_ready = in_ready_q;
    assign bus.pe_valid = pending_q;
    assign bus.pe_data  = pe_data_q;
    assign err_nomatch  = err_q;
    assign drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_glb_mc_tag_bus.sv
// Directed bench for glb_mc_tag_bus on a 4x8 grid with kernel_size=3.
module tb_glb_mc_tag_bus;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        auto_req;
    logic [7:0]  kernel_size;
    logic        busy;
    logic        cfg_we;
    logic [4:0]  cfg_idx;
    logic        cfg_en;
    logic [3:0]  cfg_row_tag;
    logic [3:0]  cfg_col_tag;
    logic        err_nomatch;
    logic [15:0] drop_cnt;

    int checks   = 0;
    int failures = 0;
    int n;
    int acc;
    logic rdy;

    glb_mc_tag_bus_if #(.DATA_WIDTH(16), .NUM_ROW(4), .NUM_COL(8), .TAG_W(4)) bus_if ();

    glb_mc_tag_bus #(
        .DATA_WIDTH(16), .NUM_ROW(4), .NUM_COL(8), .TAG_W(4), .FIFO_DEPTH(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .auto_req    (auto_req),
        .kernel_size (kernel_size),
        .busy        (busy),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_en      (cfg_en),
        .cfg_row_tag (cfg_row_tag),
        .cfg_col_tag (cfg_col_tag),
        .bus         (bus_if),
        .err_nomatch (err_nomatch),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and hold it until the edge that accepts it.
    task automatic send(input logic [15:0] d, input logic [3:0] r, input logic [3:0] c);
        int waited = 0;
        bus_if.in_data    = d;
        bus_if.in_row_tag = r;
        bus_if.in_col_tag = c;
        bus_if.in_valid   = 1'b1;
        while (!bus_if.in_ready && waited < 50) begin
            tick();
            waited++;
        end
        check_eq("send_ready", bus_if.in_ready, 1);
        tick();
        bus_if.in_valid = 1'b0;
        $display("send data=0x%h row=%0d col=%0d", d, r, c);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; auto_req = 1'b0; kernel_size = 8'd3;
        cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_row_tag = '0; cfg_col_tag = '0;
        bus_if.in_valid = 1'b0; bus_if.in_data = '0;
        bus_if.in_row_tag = '0; bus_if.in_col_tag = '0;
        bus_if.pe_ready = '1;
        repeat (2) tick();

        // Reset values
        check_eq("rst_busy", busy, 1);
        check_eq("rst_in_ready", bus_if.in_ready, 0);
        check_eq("rst_pe_valid", bus_if.pe_valid, 0);
        check_eq("rst_pe_data", bus_if.pe_data, 0);
        check_eq("rst_err", err_nomatch, 0);
        check_eq("rst_drop_cnt", drop_cnt, 0);

        // 1: allocation walk, then a point-to-point word to PE 10
        rst = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        check_eq("auto_busy_cycles", n, 32);
        check_eq("run_in_ready", bus_if.in_ready, 1);
        send(16'h1234, 4'd1, 4'd2);
        check_eq("s1_latency_zero", bus_if.pe_valid, 0);
        tick();
        check_eq("s1_pe_valid", bus_if.pe_valid, 32'h0000_0400);
        check_eq("s1_pe_data", bus_if.pe_data, 16'h1234);
        tick();
        check_eq("s1_cleared", bus_if.pe_valid, 0);

        // 2: column broadcast on row 0 reaches only enabled columns 0..2
        send(16'hA5A5, 4'd0, 4'hF);
        tick();
        check_eq("s2_pe_valid", bus_if.pe_valid, 32'h0000_0007);
        tick();
        check_eq("s2_cleared", bus_if.pe_valid, 0);

        // 3: row broadcast with PE 9 stalled; a second word waits behind it
        bus_if.pe_ready[9] = 1'b0;
        send(16'h3333, 4'hF, 4'd1);
        bus_if.in_data = 16'h4444; bus_if.in_row_tag = 4'd0; bus_if.in_col_tag = 4'd0;
        bus_if.in_valid = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        check_eq("s3_all_three", bus_if.pe_valid, 32'h0002_0202);
        check_eq("s3_data", bus_if.pe_data, 16'h3333);
        tick();
        check_eq("s3_hold_c2", bus_if.pe_valid, 32'h0000_0200);
        tick();
        check_eq("s3_hold_c3", bus_if.pe_valid, 32'h0000_0200);
        tick();
        check_eq("s3_hold_c4", bus_if.pe_valid, 32'h0000_0200);
        check_eq("s3_data_stable", bus_if.pe_data, 16'h3333);
        bus_if.pe_ready[9] = 1'b1;
        tick();
        check_eq("s3_next_word", bus_if.pe_valid, 32'h0000_0001);
        check_eq("s3_next_data", bus_if.pe_data, 16'h4444);
        tick();
        check_eq("s3_cleared", bus_if.pe_valid, 0);

        // 4: all PEs stalled, 6 words offered -> stage + 4 FIFO entries accepted
        bus_if.pe_ready = '0;
        acc = 0;
        bus_if.in_row_tag = 4'd0; bus_if.in_col_tag = 4'd0;
        for (int c = 0; c < 10; c++) begin
            rdy = bus_if.in_ready;
            bus_if.in_valid = (acc < 6);
            bus_if.in_data  = 16'h0100 + 16'(acc);
            tick();
            if (rdy && acc < 6) acc++;
        end
        bus_if.in_valid = 1'b0;
        $display("s4 accepted %0d words", acc);
        check_eq("s4_accepted", acc, 5);
        check_eq("s4_in_ready_low", bus_if.in_ready, 0);
        bus_if.pe_ready = '1;
        for (int j = 0; j < 5; j++) begin
            check_eq("s4_order_valid", bus_if.pe_valid, 32'h0000_0001);
            check_eq("s4_order_data", bus_if.pe_data, 16'h0100 + 16'(j));
            tick();
        end
        check_eq("s4_drained", bus_if.pe_valid, 0);
        check_eq("s4_in_ready_back", bus_if.in_ready, 1);

        // 5: unmatched word is dropped; a cfg write then makes PE 24 a target
        send(16'h5555, 4'd3, 4'd0);
        check_eq("s5_err_before", err_nomatch, 0);
        tick();
        check_eq("s5_err_pulse", err_nomatch, 1);
        check_eq("s5_drop_cnt", drop_cnt, 1);
        check_eq("s5_no_valid", bus_if.pe_valid, 0);
        tick();
        check_eq("s5_err_cleared", err_nomatch, 0);
        cfg_we = 1'b1; cfg_idx = 5'd24; cfg_en = 1'b1; cfg_row_tag = 4'd3; cfg_col_tag = 4'd0;
        tick();
        cfg_we = 1'b0;
        send(16'h6666, 4'd3, 4'd0);
        tick();
        check_eq("s5_pe24", bus_if.pe_valid, 32'h0100_0000);
        check_eq("s5_pe24_data", bus_if.pe_data, 16'h6666);
        tick();

        // 6: flush with words queued behind a stalled PE 0
        bus_if.pe_ready[0] = 1'b0;
        send(16'h0A00, 4'd0, 4'd0);
        send(16'h0A01, 4'd0, 4'd0);
        send(16'h0A02, 4'd0, 4'd0);
        send(16'h0A03, 4'd0, 4'd0);
        check_eq("s6_stalled", bus_if.pe_valid, 32'h0000_0001);
        check_eq("s6_stalled_data", bus_if.pe_data, 16'h0A00);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("s6_valid_cleared", bus_if.pe_valid, 0);
        check_eq("s6_busy_c1", busy, 1);
        check_eq("s6_in_ready_c1", bus_if.in_ready, 0);
        tick();
        check_eq("s6_busy_c2", busy, 1);
        check_eq("s6_in_ready_c2", bus_if.in_ready, 0);
        tick();
        check_eq("s6_busy_done", busy, 0);
        check_eq("s6_in_ready_back", bus_if.in_ready, 1);
        bus_if.pe_ready = '1;
        tick();
        check_eq("s6_nothing_left", bus_if.pe_valid, 0);
        send(16'h1234, 4'd1, 4'd2);
        tick();
        check_eq("s6_tags_kept", bus_if.pe_valid, 32'h0000_0400);
        check_eq("s6_drop_kept", drop_cnt, 1);
        tick();

        // 7: re-run allocation with kernel_size=1; only PE 0 remains enabled
        kernel_size = 8'd1;
        auto_req = 1'b1;
        tick();
        auto_req = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        check_eq("s7_auto_cycles", n, 32);
        send(16'h7777, 4'hF, 4'hF);
        tick();
        check_eq("s7_only_pe0", bus_if.pe_valid, 32'h0000_0001);
        tick();
        check_eq("s7_cleared", bus_if.pe_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/glb_mc_tag_bus.md
Name: glb_mc_tag_bus

Overview:
- Next-generation global multicast bus for the PE array, generalised from one X-bus row to a NUM_ROW x NUM_COL grid.
- Adds per-PE row/col tag registers, automatic tag allocation from kernel_size, and runtime tag reprogramming.
- Adds an input FIFO and per-PE valid/ready handshake with independent backpressure.
- Each accepted word is delivered once to every enabled PE whose row and col tags match the word's tags.

Parameters:
DATA_WIDTH, 16, payload width
NUM_ROW, 4, PE rows
NUM_COL, 8, PE columns
TAG_W, $clog2(NUM_COL)+1, tag width; all-ones = broadcast (BCAST)
FIFO_DEPTH, 4, input FIFO entries (power of 2, >=2)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  pulse: discard all buffered data
auto_req  in  1  pulse: rerun automatic tag allocation
kernel_size  in  8  kernel size used by auto allocation
busy  out  1  high in AUTO or FLUSH
cfg_we  in  1  manual tag write strobe
cfg_idx  in  $clog2(NUM_ROW*NUM_COL)  PE index = r*NUM_COL+c
cfg_en  in  1  enable bit written
cfg_row_tag  in  TAG_W  row tag written
cfg_col_tag  in  TAG_W  col tag written
in_valid  in  1  source valid
in_ready  out  1  source ready
in_data  in  DATA_WIDTH  payload
in_row_tag  in  TAG_W  destination row tag
in_col_tag  in  TAG_W  destination col tag
pe_valid  out  NUM_ROW*NUM_COL  per-PE valid, bit = r*NUM_COL+c
pe_ready  in  NUM_ROW*NUM_COL  per-PE ready
pe_data  out  DATA_WIDTH  shared payload to all PEs
err_nomatch  out  1  one-cycle pulse on a dropped word
drop_cnt  out  16  saturating count of dropped words

Behaviour:
- Reset: all outputs 0 except busy=1; FIFO, output stage, and tags cleared; all PEs disabled. State = AUTO on the first edge after rst falls.
- FSM states: AUTO, RUN, FLUSH.
- AUTO:
  - Visits one PE per cycle, idx 0..NUM_ROW*NUM_COL-1; lasts exactly NUM_ROW*NUM_COL cycles, then RUN.
  - Let K = min(kernel_size, NUM_COL) for columns and min(kernel_size, NUM_ROW) for rows.
  - PE(r,c) enabled iff c < column K and r < row K; row_tag = r, col_tag = c. kernel_size = 0 disables all PEs.
  - in_ready = 0; cfg_we, flush, and auto_req are ignored.
- RUN:
  - in_ready = !fifo_full.
  - cfg_we writes the tag registers of cfg_idx at the edge.
  - auto_req is accepted only when FIFO and output stage are empty; it then enters AUTO and samples kernel_size each AUTO cycle. Otherwise auto_req is ignored.
- Match rule: PE p matches iff en[p] && (in_row_tag == row_tag[p] || in_row_tag == BCAST) && (in_col_tag == col_tag[p] || in_col_tag == BCAST).
- Load and match timing:
  - The mask is computed when the FIFO head loads into the output stage, using tags current at that edge.
  - Tag writes do not alter a word already in the stage.
- Output stage:
  - Holds pe_data and a pending mask; pe_valid = pending.
  - At each edge, pending &= ~pe_ready. A PE that accepted sees its valid drop next cycle while the others hold.
  - The stage frees when pending becomes 0. It reloads from the FIFO head on the same edge, so throughput is 1 word/cycle when all targets are ready.
  - pe_data is stable while pending != 0.
- Latency: a word accepted at edge k into an empty FIFO and empty stage has pe_valid high from edge k+1.
- Mask == 0 at load: word dropped, stage stays empty, err_nomatch pulses for 1 cycle, drop_cnt increments and saturates at 0xFFFF.
- FIFO: simultaneous push and pop when full is allowed only if the pop frees a slot in the same cycle; in_ready does not depend on the pop (registered full flag).
- FLUSH:
  - Entered from RUN on flush.
  - Clears FIFO, stage, and pending at that edge; pe_valid = 0 the next cycle.
  - Lasts 2 cycles with busy = 1 and in_ready = 0, then RUN.
  - Tags and drop_cnt are kept. flush during FLUSH restarts the 2-cycle count.
- Simultaneous events in RUN: flush has priority over auto_req and cfg_we. cfg_we and a load in the same cycle use the old tags.
- Reset mid-operation discards everything immediately and re-runs AUTO.

Test Plan:
1. NUM_ROW=4, NUM_COL=8, kernel_size=3, release rst -> busy high 32 cycles; then word D=0x1234, row=1, col=2 -> only pe_valid[10] high, pe_data=0x1234, 1 cycle after acceptance.
2. Word row=0, col=BCAST (0xF), all ready -> pe_valid bits 0,1,2 high for 1 cycle; bits 3..7 never set.
3. Row=BCAST, col=1, pe_ready[9]=0 for 3 cycles -> pe_valid[1] and [17] drop after 1 cycle; pe_valid[9] held 4 cycles; next word is not presented until bit 9 clears.
4. All pe_ready=0 with target PE 0, push 6 words -> in_ready falls after stage + 4 FIFO words (5 accepted); release ready -> 5 words delivered in order, 1 per cycle.
5. kernel_size=3, word row=3, col=0 -> err_nomatch pulse, drop_cnt=1, no pe_valid; cfg_we idx=24 en=1 row=3 col=0, resend -> pe_valid[24] high.
6. 3 words queued behind a stalled PE, pulse flush -> pe_valid=0 next cycle, busy high 2 cycles, in_ready then 1, tags preserved (scenario 1 word still reaches pe 10).
